// File: rtl/biquad8_coeff_sequencer.sv
// WISHBONE coefficient manager that streams per-channel shadow RAM contents into biquad8 channels.
// Define BIQUAD_SEQ_READBACK_EN to give the shadow RAM a bus read port; otherwise shadow reads return 0.
module biquad8_coeff_sequencer #(
  parameter int NCHAN  = 4,
  parameter int NZERO  = 2,
  parameter int NIIR   = 7,
  // Derived; not meant to be overridden.
  parameter int CHBITS = (NCHAN > 1) ? $clog2(NCHAN) : 1,
  parameter int NCOEFF = NZERO + 4 + NIIR,
  parameter int AW     = CHBITS + 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  input  logic              global_update_i,
  output logic [17:0]       coeff_dat_o,
  output logic [NCHAN-1:0]  coeff_fir_wr_o,
  output logic [NCHAN-1:0]  coeff_polefir_wr_o,
  output logic [1:0]        coeff_polefir_adr_o,
  output logic [NCHAN-1:0]  coeff_iir_wr_o,
  output logic              coeff_update_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_UPDATE} state_t;

  localparam logic [CHBITS:0] NCHAN_W   = (CHBITS + 1)'(NCHAN);
  localparam logic [4:0]      NCOEFF_W  = 5'(NCOEFF);
  localparam logic [3:0]      LAST_SLOT = 4'(NCOEFF - 1);
  localparam logic [3:0]      PF_FIRST  = 4'(NZERO);
  localparam logic [3:0]      IIR_FIRST = 4'(NZERO + 4);

  logic [17:0] mem [NCHAN][NCOEFF];

  state_t            state_q, state_d;
  logic [CHBITS-1:0] cur_ch_q;
  logic [3:0]        cur_slot_q;
  logic [NCHAN-1:0]  chmask_q, load_mask_q, ch_onehot;
  logic              auto_q, pend_q, start_q, ack_q;
  logic [31:0]       dat_q, rd_data;
  logic [17:0]       coeff_q;
  logic [NCHAN-1:0]  fir_q, pf_q, iir_q;
  logic [1:0]        pf_adr_q;
  logic [CHBITS:0]   first, nxt;

  // Bus decode
  logic              bus_req, is_ctrl, shadow_hit, busy, stall, accept, wr_acc;
  logic              ctrl_wr, start_wr;
  logic [CHBITS-1:0] adr_ch;
  logic [3:0]        adr_slot;

  assign bus_req    = wb_cyc_i & wb_stb_i;
  assign is_ctrl    = wb_adr_i[AW-1];
  assign adr_ch     = wb_adr_i[AW-2:6];
  assign adr_slot   = wb_adr_i[5:2];
  assign shadow_hit = ~is_ctrl && ({1'b0, adr_ch} < NCHAN_W) && ({1'b0, adr_slot} < NCOEFF_W);
  assign busy       = (state_q != S_IDLE);
  // A pending start counts as busy so no shadow write can slip in ahead of the load.
  assign stall      = wb_we_i & ~is_ctrl & (busy | start_q);
  assign accept     = bus_req & ~stall & ~ack_q;
  assign wr_acc     = accept & wb_we_i;
  assign ctrl_wr    = wr_acc & is_ctrl & (adr_slot == 4'd0) & wb_sel_i[0] & ~busy & ~start_q;
  assign start_wr   = ctrl_wr & wb_dat_i[0];

  logic unused_bits;
  assign unused_bits = &{1'b0, wb_dat_i[31:18], wb_sel_i[3:1], wb_adr_i[1:0]};

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (is_ctrl) begin
      if (adr_slot == 4'd0)      rd_data = {23'b0, busy, 6'b0, auto_q, 1'b0};
      else if (adr_slot == 4'd1) rd_data[NCHAN-1:0] = chmask_q;
    end
`ifdef BIQUAD_SEQ_READBACK_EN
    else if (shadow_hit) begin
      rd_data = {14'b0, mem[adr_ch][adr_slot]};
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      chmask_q <= '1;
      auto_q   <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      ack_q   <= accept;
      dat_q   <= (accept && !wb_we_i) ? rd_data : '0;
      start_q <= start_wr | (start_q & (state_q != S_IDLE));
      if (ctrl_wr) auto_q <= wb_dat_i[1];
      if (wr_acc && is_ctrl && adr_slot == 4'd1) begin
        for (int i = 0; i < NCHAN; i++)
          if (wb_sel_i[i/8]) chmask_q[i] <= wb_dat_i[i];
      end
    end
  end

  // NOTE: the shadow RAM has no reset; its contents are defined only by bus writes.
  always_ff @(posedge clk_i) begin
    if (wr_acc && shadow_hit) mem[adr_ch][adr_slot] <= wb_dat_i[17:0];
  end

  // Lowest selected channel at or above lo; MSB flags that one was found.
  function automatic logic [CHBITS:0] find_ch(input logic [NCHAN-1:0] m, input int lo);
    logic [CHBITS:0] r;
    r = '0;
    for (int i = NCHAN - 1; i >= 0; i--)
      if (m[i] && i >= lo) r = {1'b1, CHBITS'(i)};
    return r;
  endfunction

  assign first     = find_ch(chmask_q, 0);
  assign nxt       = find_ch(load_mask_q, int'(cur_ch_q) + 1);
  assign ch_onehot = NCHAN'(1) << cur_ch_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_q)              state_d = first[CHBITS] ? S_LOAD : S_DRAIN;
        else if (global_update_i) state_d = S_UPDATE;
      end
      S_LOAD:  if (cur_slot_q == LAST_SLOT && !nxt[CHBITS]) state_d = S_DRAIN;
      S_DRAIN: state_d = (auto_q | pend_q | global_update_i) ? S_UPDATE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_mask_q <= '0;
      cur_ch_q    <= '0;
      cur_slot_q  <= '0;
      pend_q      <= 1'b0;
      coeff_q     <= '0;
      fir_q       <= '0;
      pf_q        <= '0;
      iir_q       <= '0;
      pf_adr_q    <= '0;
    end else begin
      fir_q <= '0;
      pf_q  <= '0;
      iir_q <= '0;
      case (state_q)
        S_IDLE: begin
          pend_q <= start_q & global_update_i;
          if (start_q) begin
            load_mask_q <= chmask_q;
            cur_ch_q    <= first[CHBITS-1:0];
            cur_slot_q  <= '0;
          end
        end
        S_LOAD: begin
          pend_q  <= pend_q | global_update_i;
          coeff_q <= mem[cur_ch_q][cur_slot_q];
          if (cur_slot_q < PF_FIRST) begin
            fir_q <= ch_onehot;
          end else if (cur_slot_q < IIR_FIRST) begin
            pf_q     <= ch_onehot;
            pf_adr_q <= 2'(cur_slot_q - PF_FIRST);
          end else begin
            iir_q <= ch_onehot;
          end
          if (cur_slot_q == LAST_SLOT) begin
            cur_slot_q <= '0;
            cur_ch_q   <= nxt[CHBITS-1:0];
          end else begin
            cur_slot_q <= cur_slot_q + 4'd1;
          end
        end
        default: pend_q <= 1'b0;
      endcase
    end
  end

  assign wb_dat_o            = dat_q;
  assign wb_ack_o            = ack_q;
  assign wb_err_o            = 1'b0;
  assign wb_rty_o            = 1'b0;
  assign coeff_dat_o         = coeff_q;
  assign coeff_fir_wr_o      = fir_q;
  assign coeff_polefir_wr_o  = pf_q;
  assign coeff_polefir_adr_o = pf_adr_q;
  assign coeff_iir_wr_o      = iir_q;
  assign coeff_update_o      = (state_q == S_UPDATE);
  assign busy_o              = busy;

endmodule

// File: tb/tb_biquad8_coeff_sequencer.sv
// Directed bench for biquad8_coeff_sequencer: bus access, streaming order/timing, update merging, reset.
// Honours BIQUAD_SEQ_READBACK_EN for the shadow readback expectation.
module tb_biquad8_coeff_sequencer;

  localparam logic [8:0] CTRL   = 9'h100;
  localparam logic [8:0] CHMASK = 9'h104;
  localparam logic [8:0] BADREG = 9'h108;

  logic        clk, rst_n;
  logic        cyc, stb, we, gupd;
  logic [8:0]  adr;
  logic [31:0] wdat, rdat_o;
  logic [3:0]  sel;
  logic        ack, err, rty, upd, busy;
  logic [17:0] cdat;
  logic [3:0]  fir_wr, pf_wr, iir_wr;
  logic [1:0]  pf_adr;

  biquad8_coeff_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(rdat_o), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .global_update_i(gupd),
    .coeff_dat_o(cdat), .coeff_fir_wr_o(fir_wr), .coeff_polefir_wr_o(pf_wr),
    .coeff_polefir_adr_o(pf_adr), .coeff_iir_wr_o(iir_wr),
    .coeff_update_o(upd), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct {int cyc; int kind; int ch; int adr; logic [17:0] dat;} ev_t;
  ev_t  log_q[$];
  ev_t  ev;
  int   upd_cnt, upd_cyc, onehot_bad, busy_fall;
  logic busy_prev = 1'b0;
  logic [3:0] chv;

  // Strobe/update monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if ({iir_wr, pf_wr, fir_wr} != 12'd0) begin
        if ($countones({iir_wr, pf_wr, fir_wr}) != 1) onehot_bad++;
        chv     = fir_wr | pf_wr | iir_wr;
        ev.cyc  = cyc_n;
        ev.kind = (|fir_wr) ? 0 : (|pf_wr) ? 1 : 2;
        ev.ch   = 0;
        for (int i = 0; i < 4; i++) if (chv[i]) ev.ch = i;
        ev.adr  = (ev.kind == 1) ? int'(pf_adr) : 0;
        ev.dat  = cdat;
        log_q.push_back(ev);
      end
      if (upd) begin
        upd_cnt++;
        upd_cyc = cyc_n;
      end
    end
    if (busy_prev && !busy) busy_fall = cyc_n;
    busy_prev = busy;
  end

  int checks = 0;
  int errors = 0;
  logic [17:0] model [4][13];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    log_q.delete();
    upd_cnt    = 0;
    upd_cyc    = -1;
    onehot_bad = 0;
    busy_fall  = -1;
  endtask

  task automatic wb_xfer(input logic w, input logic [8:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output int ack_cyc);
    ack_cyc = -1;
    r = '0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        ack_cyc = cyc_n;
        r = rdat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (ack_cyc < 0) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout: observed no ack expected ack at adr %0h", a);
    end
  endtask

  task automatic wb_write(input logic [8:0] a, input logic [31:0] d, output int ack_cyc);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, 4'hF, r, ack_cyc);
  endtask

  task automatic wb_read(input logic [8:0] a, output logic [31:0] r);
    int c;
    wb_xfer(1'b0, a, 32'h0, 4'hF, r, c);
  endtask

  task automatic wait_idle();
    bit done = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL idle_timeout: observed busy expected idle");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Compares the recorded stream against the bench's own RAM image and cycle budget.
  task automatic check_seq(input string tag, input logic [3:0] mask, input int a);
    int idx = 0;
    int bad = 0;
    int kind, padr;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        for (int s = 0; s < 13; s++) begin
          kind = (s < 2) ? 0 : (s < 6) ? 1 : 2;
          padr = (kind == 1) ? s - 2 : 0;
          if (idx >= log_q.size()) bad++;
          else if (log_q[idx].cyc != a + 2 + idx || log_q[idx].kind != kind ||
                   log_q[idx].ch != ch || log_q[idx].adr != padr ||
                   log_q[idx].dat !== model[ch][s]) bad++;
          idx++;
        end
      end
    end
    check({tag, "_len"}, log_q.size(), idx);
    check({tag, "_content"}, bad, 0);
    check({tag, "_onehot"}, onehot_bad, 0);
  endtask

  int a, a2, w, g;
  logic [31:0] r;

  initial begin
    rst_n = 1'b0; cyc = 0; stb = 0; we = 0; adr = '0; wdat = '0; sel = '0; gupd = 0;
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    check("rst_stream", {cdat, fir_wr, pf_wr, pf_adr, iir_wr, upd, busy}, 64'h0);
    check("rst_bus", {ack, rdat_o, err, rty}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    wb_read(CHMASK, r);
    check("chmask_reset", r, 32'hF);
    wb_read(CTRL, r);
    check("ctrl_reset", r, 32'h0);

    for (int ch = 0; ch < 4; ch++)
      for (int s = 0; s < 13; s++) begin
        model[ch][s] = 18'((ch * 13 + s) * 4099 + 341);
        wb_write(9'(ch * 64 + s * 4), {14'h2A5A, model[ch][s]}, w);
      end

    wb_write(9'(2 * 64 + 5 * 4), 32'h0003ABCD, w);
    model[2][5] = 18'h3ABCD;
    wb_read(9'(2 * 64 + 5 * 4), r);
`ifdef BIQUAD_SEQ_READBACK_EN
    check("readback", r, 32'h0003ABCD);
`else
    check("readback", r, 32'h0);
`endif

    wb_write(9'(1 * 64 + 14 * 4), 32'h1234, w);
    wb_read(9'(1 * 64 + 14 * 4), r);
    check("slot14_read", r, 32'h0);
    wb_write(BADREG, 32'hFFFF_FFFF, w);
    wb_read(BADREG, r);
    check("badreg_read", r, 32'h0);

    // External update while idle
    clear_log();
    gupd = 1'b1; g = cyc_n;
    @(posedge clk); #1;
    gupd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("gidle_cnt", upd_cnt, 1);
    check("gidle_cyc", upd_cyc, g + 1);

    // Full load with AUTO
    clear_log();
    wb_write(CHMASK, 32'hF, w);
    wb_write(CTRL, 32'h3, a);
    check("busy_at_A", busy, 1'b0);
    @(posedge clk); #1;
    check("busy_at_A1", busy, 1'b1);
    wait_idle();
    check_seq("full", 4'hF, a);
    check("full_upd_cnt", upd_cnt, 1);
    check("full_upd_cyc", upd_cyc, a + 54);
    check("full_busy_fall", busy_fall, a + 55);
    wb_read(CTRL, r);
    check("ctrl_auto", r, 32'h2);

    // Sparse mask, no AUTO
    clear_log();
    wb_write(CHMASK, 32'h5, w);
    wb_write(CTRL, 32'h1, a);
    wait_idle();
    check_seq("sparse", 4'h5, a);
    check("sparse_upd_cnt", upd_cnt, 0);
    check("sparse_busy_fall", busy_fall, a + 28);

    // External update during a load merges into one pulse after the last strobe
    clear_log();
    wb_write(CHMASK, 32'h1, w);
    wb_write(CTRL, 32'h1, a);
    repeat (4) @(posedge clk);
    #1;
    gupd = 1'b1;
    @(posedge clk); #1;
    gupd = 1'b0;
    wait_idle();
    check_seq("gload", 4'h1, a);
    check("gload_upd_cnt", upd_cnt, 1);
    check("gload_upd_cyc", upd_cyc, a + 15);
    check("gload_busy_fall", busy_fall, a + 16);

    // Restart and shadow write while busy
    clear_log();
    wb_write(CHMASK, 32'hF, w);
    wb_write(CTRL, 32'h3, a);
    repeat (3) @(posedge clk);
    #1;
    wb_write(CTRL, 32'h3, a2);
    check("restart_acked_busy", busy, 1'b1);
    wb_write(9'(3 * 64), 32'h2F0F0, w);
    check("stall_ack_cyc", w, a + 56);
    repeat (3) @(posedge clk);
    #1;
    check_seq("busyload", 4'hF, a);
    check("busyload_upd_cnt", upd_cnt, 1);
    check("busyload_upd_cyc", upd_cyc, a + 54);
    model[3][0] = 18'h2F0F0;

    clear_log();
    wb_write(CHMASK, 32'h8, w);
    wb_write(CTRL, 32'h1, a);
    wait_idle();
    check_seq("ch3", 4'h8, a);
    check("ch3_upd_cnt", upd_cnt, 0);

    // Empty mask with AUTO
    clear_log();
    wb_write(CHMASK, 32'h0, w);
    wb_write(CTRL, 32'h3, a);
    wait_idle();
    check("empty_strobes", log_q.size(), 0);
    check("empty_upd_cnt", upd_cnt, 1);
    check("empty_upd_cyc", upd_cyc, a + 2);
    check("empty_busy_fall", busy_fall, a + 3);

    // Reset in the middle of a load
    wb_write(CHMASK, 32'hF, w);
    wb_write(CTRL, 32'h3, a);
    for (int i = 0; i < 20 && cyc_n < a + 10; i++) begin
      @(posedge clk); #1;
    end
    check("midload_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {cdat, fir_wr, pf_wr, pf_adr, iir_wr, upd, busy}, 64'h0);
    clear_log();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (70) @(posedge clk);
    #1;
    check("midrst_upd_cnt", upd_cnt, 0);
    check("midrst_strobes", log_q.size(), 0);
    wb_read(CHMASK, r);
    check("midrst_chmask", r, 32'hF);
    wb_read(CTRL, r);
    check("midrst_ctrl", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/biquad8_coeff_sequencer.md
# biquad8_coeff_sequencer

Single-clock WISHBONE coefficient manager for a bank of NCHAN biquad8 filter channels. It holds a per-channel shadow RAM of 18-bit coefficients with optional readback. On command, it streams the selected channels' coefficients into their zero-FIR, pole-FIR and pole-IIR coefficient ports, one word per clock. It then issues one broadcast coefficient update, so all channels switch on the same cycle. It sits between the control bus and the biquad8 filter channels in the filter clock domain.

## Interface
- NCHAN, 4: number of filter channels (1..16); CHBITS = max(1, clog2(NCHAN)).
- NZERO, 2: zero-FIR coefficients per channel, slots 0..NZERO-1.
- NIIR, 7: pole-IIR coefficients per channel, slots NZERO+4..NCOEFF-1.
- NCOEFF is derived as NZERO+4+NIIR and must be ≤16. Slots NZERO..NZERO+3 are pole-FIR, with address 0..3.
- AW is derived as CHBITS+7: byte address width.

Ports:
- clk_i  in  1  sole clock.
- rst_ni  in  1  asynchronous, active-low reset.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  WISHBONE target controls.
- wb_adr_i  in  AW  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte selects.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- wb_err_o, wb_rty_o  out  1  tied 0.
- global_update_i  in  1  external simultaneous-update request.
- coeff_dat_o  out  18  coefficient word shared by all channels.
- coeff_fir_wr_o  out  NCHAN  per-channel zero-FIR write strobe.
- coeff_polefir_wr_o  out  NCHAN  per-channel pole-FIR write strobe.
- coeff_polefir_adr_o  out  2  pole-FIR coefficient address.
- coeff_iir_wr_o  out  NCHAN  per-channel pole-IIR write strobe.
- coeff_update_o  out  1  broadcast update pulse.
- busy_o  out  1  load in progress.

## Operation
Address map:
- adr[AW-1]=0 selects shadow RAM: channel = adr[AW-2:6], slot = adr[5:2]. Writes store wb_dat_i[17:0]. Slot ≥ NCOEFF or channel ≥ NCHAN: write discarded, read returns 0.
- 0x{1,00000..} CTRL (adr[AW-1]=1, adr[5:2]=0):
  - Write bit0=1 with sel[0] starts a load.
  - bit1 = AUTO: issue update at end of load.
  - Read returns {busy in bit8, AUTO in bit1}.
- CTRL+4 CHMASK: bits [NCHAN-1:0] select the channels to load. Reset value is all ones. Readable.
- Other control offsets: writes are discarded, reads return 0.

FSM states:
- IDLE: a start moves to LOAD.
- LOAD: walks the selected channels in ascending order, skipping unselected channels with zero cycles spent. Within a channel it walks slots 0..NCOEFF-1, issuing one RAM read per cycle. Registered RAM output appears the following cycle with exactly one strobe: fir if slot<NZERO; polefir with adr=slot-NZERO if slot<NZERO+4; else iir. Only the current channel's bit is asserted.
- LOAD → DRAIN after the last read is issued. DRAIN is one cycle that emits the last strobe.
- DRAIN → UPDATE if AUTO or a pending global update, else → IDLE.
- UPDATE: coeff_update_o=1 for one cycle → IDLE.
- Empty CHMASK on start: IDLE→DRAIN immediately, with no strobes.

Bus rules:
- Shadow-RAM writes while busy_o are stalled (no ack) until IDLE.
- Reads and control accesses are never stalled.
- A start while busy is acked and ignored.
- global_update_i in IDLE: coeff_update_o pulses the next cycle.
- global_update_i while busy: latched and merged into the single UPDATE pulse.

## Timing
- Reset: all outputs 0, FSM IDLE, CHMASK all ones, AUTO 0. Shadow RAM is not reset.
- wb_ack_o is registered. It goes high the cycle after cyc&stb&(not stalled), for one cycle, and never back-to-back for the same strobe.
- Start acked at cycle A: busy_o is 1 from A+1. The first strobe is at A+2. The last strobe is at A+1+K·NCOEFF, where K = popcount(CHMASK).
- With an update: coeff_update_o is at A+2+K·NCOEFF, and busy_o falls at A+3+K·NCOEFF. Without an update, busy_o falls at A+2+K·NCOEFF.
- Reset mid-load: strobes and update drop immediately, and no update is issued.

## Configuration
- BIQUAD_SEQ_READBACK_EN defined: shadow-RAM reads return {14'b0, coeff} with 1-cycle ack.
- BIQUAD_SEQ_READBACK_EN undefined: shadow reads return 0, and the RAM has no bus read port (sequencer port only). Control-register reads are unaffected.

## Test plan
- Test parameters are NCHAN=4, NZERO=2, NIIR=7, NCOEFF=13.
- Readback (READBACK_EN defined): write 0x3ABCD to ch2 slot5, read back → wb_dat_o=0x0003ABCD. With the macro undefined, the same read → 0.
- Full load with AUTO: CHMASK=0xF, CTRL=0x3 acked at A → 52 strobes at A+2..A+53, each one-hot. Per channel: fir×2, polefir adr 0,1,2,3, iir×7; data matches RAM. Update at A+54; busy_o low at A+55.
- Sparse mask, no AUTO: CHMASK=0x5, CTRL=0x1 → only ch0 then ch2 strobes (26 cycles), no coeff_update_o.
- A global_update_i pulse mid-load produces exactly one coeff_update_o, after the last strobe.
- Busy interactions: a shadow write issued during a load is not acked until IDLE, then is stored, and the streamed data is unaffected. A CTRL start during busy is acked with no restart.
- Reset and boundaries: assert rst_ni low at A+10 → all outputs 0 asynchronously, busy_o 0, no update. An empty-mask start with AUTO → update at A+2, no strobes. A write to slot 14 is discarded and reads 0.
